// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared constants and types for the flappy game blocks
// Purpose: common widths, screen geometry and the flap request FSM state type.
// Ports: none (package).
package flappy_pkg;

   // Physics tick counter width; the flap hold window matches one tick period.
   localparam int TICK_BITS = 20;

   // Geometry used by sibling blocks.
   localparam int SCREEN_H  = 480;
   localparam int BIRD_H    = 32;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } flap_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus counting debouncer
// Purpose: bring the raw button into the clock domain and only follow a new level
//          after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk_i       in   system clock
//   reset_n_i   in   synchronous reset, active low
//   btn_raw_i   in   raw asynchronous button, active high
//   db_level_o  out  debounced button level
//   rise_o      out  combinational strobe, high in the cycle db_level is about to rise
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic btn_raw_i,
   output logic db_level_o,
   output logic rise_o
);

   localparam int               DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            s1_q;
   logic            s2_q;
   logic            db_level_q;
   logic            db_level_d;
   logic [DB_W-1:0] db_cnt_q;
   logic [DB_W-1:0] db_cnt_d;
   logic            at_max;

   assign at_max = (db_cnt_q == DB_MAX);

   // Any cycle where s2 agrees with the debounced level restarts the count, so
   // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
   always_comb begin
      db_level_d = db_level_q;
      db_cnt_d   = db_cnt_q;
      if (s2_q == db_level_q) begin
         db_cnt_d = '0;
      end else if (at_max) begin
         db_level_d = s2_q;
         db_cnt_d   = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         db_level_q <= 1'b0;
         db_cnt_q   <= '0;
      end else begin
         s1_q       <= btn_raw_i;
         s2_q       <= s1_q;
         db_level_q <= db_level_d;
         db_cnt_q   <= db_cnt_d;
      end
   end

   assign db_level_o = db_level_q;
   assign rise_o     = s2_q & ~db_level_q & at_max;

endmodule

// File: rtl/flap_request_gen.sv
// rtl/flap_request_gen.sv - debounced button to held flap request for bird_physics
// Purpose: turn each debounced press into a flap_btn window exactly one physics tick
//          long, queue one further press, and count accepted and dropped presses.
// Ports:
//   clk          in   system clock
//   reset_n      in   synchronous reset, active low
//   btn_raw      in   raw asynchronous button, active high
//   flap_btn     out  flap request, high for whole hold windows
//   press_pulse  out  one-cycle strobe per debounced rising edge
//   busy         out  high while holding
//   pending      out  one queued press waiting
//   flap_count   out  accepted presses, saturating
//   drop_count   out  discarded presses, saturating
module flap_request_gen
   import flappy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_BITS       = TICK_BITS,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_raw,
   output logic             flap_btn,
   output logic             press_pulse,
   output logic             busy,
   output logic             pending,
   output logic [CNT_W-1:0] flap_count,
   output logic [CNT_W-1:0] drop_count
);

   flap_state_e          state_q;
   flap_state_e          state_d;
   logic [HOLD_BITS-1:0] hold_cnt_q;
   logic [HOLD_BITS-1:0] hold_cnt_d;
   logic                 pending_q;
   logic                 pending_d;
   logic [CNT_W-1:0]     flap_count_q;
   logic [CNT_W-1:0]     flap_count_d;
   logic [CNT_W-1:0]     drop_count_q;
   logic [CNT_W-1:0]     drop_count_d;
   logic                 press_pulse_q;

   logic                 db_level;
   logic                 rise;
   logic                 press;
   logic                 window_end;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .btn_raw_i  (btn_raw),
      .db_level_o (db_level),
      .rise_o     (rise)
   );

   // A press is only taken while the debounced level is still low, i.e. on the
   // cycle it is about to rise.
   assign press      = rise & ~db_level;
   assign window_end = (state_q == HOLD) && (hold_cnt_q == {HOLD_BITS{1'b1}});

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      pending_d    = pending_q;
      flap_count_d = flap_count_q;
      drop_count_d = drop_count_q;
      case (state_q)
         IDLE: begin
            if (press) begin
               state_d      = HOLD;
               hold_cnt_d   = '0;
               flap_count_d = sat_inc(flap_count_q);
            end
         end
         HOLD: begin
            // Wraps to zero on the window-end cycle, which is exactly the restart value.
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (window_end) begin
               if (pending_q) begin
                  // Queued press starts the next window; a press arriving on the same
                  // cycle takes over the now-empty queue slot.
                  pending_d    = press;
                  flap_count_d = sat_inc(flap_count_q);
               end else if (press) begin
                  flap_count_d = sat_inc(flap_count_q);
               end else begin
                  state_d = IDLE;
               end
            end else if (press) begin
               if (pending_q) begin
                  drop_count_d = sat_inc(drop_count_q);
               end else begin
                  pending_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         pending_q     <= 1'b0;
         flap_count_q  <= '0;
         drop_count_q  <= '0;
         press_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         pending_q     <= pending_d;
         flap_count_q  <= flap_count_d;
         drop_count_q  <= drop_count_d;
         press_pulse_q <= rise;
      end
   end

   assign flap_btn    = (state_q == HOLD);
   assign busy        = (state_q == HOLD);
   assign pending     = pending_q;
   assign press_pulse = press_pulse_q;
   assign flap_count  = flap_count_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_flap_request_gen.sv
// tb/tb_flap_request_gen.sv - self-checking bench for flap_request_gen
module tb_flap_request_gen;

   localparam int DB       = 4;
   localparam int HB       = 4;
   localparam int CW       = 8;
   localparam int HOLD_LEN = 1 << HB;
   localparam int CNT_MAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          btn_raw = 1'b0;
   logic          flap_btn;
   logic          press_pulse;
   logic          busy;
   logic          pending;
   logic [CW-1:0] flap_count;
   logic [CW-1:0] drop_count;

   always #5 clk = ~clk;

   flap_request_gen #(
      .DEBOUNCE_CYCLES (DB),
      .HOLD_BITS       (HB),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw),
      .flap_btn    (flap_btn),
      .press_pulse (press_pulse),
      .busy        (busy),
      .pending     (pending),
      .flap_count  (flap_count),
      .drop_count  (drop_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: button history, a mismatch run length, and the number of
   // flap cycles still owed rather than an up-counter.
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_pp = 1'b0;
   int   m_diff = 0, m_rem = 0, m_pend = 0, m_fc = 0, m_dc = 0;

   int   hi_cycles = 0, hi_runs = 0;
   logic prev_fb = 1'b0, pend_seen = 1'b0;

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   task automatic model_step(input logic rstn, input logic raw);
      logic r;
      if (!rstn) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pp = 0;
         m_diff = 0; m_rem = 0; m_pend = 0; m_fc = 0; m_dc = 0;
      end else begin
         r = 1'b0;
         if (m_s2 != m_lvl) begin
            m_diff++;
            if (m_diff == DB) begin
               m_lvl  = m_s2;
               m_diff = 0;
               r      = m_lvl;
            end
         end else begin
            m_diff = 0;
         end
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               if (m_pend != 0) begin
                  m_pend = r ? 1 : 0;
                  m_rem  = HOLD_LEN;
                  m_fc   = sat(m_fc);
               end else if (r) begin
                  m_rem = HOLD_LEN;
                  m_fc  = sat(m_fc);
               end
            end else if (r) begin
               if (m_pend != 0) m_dc = sat(m_dc);
               else m_pend = 1;
            end
         end else if (r) begin
            m_rem = HOLD_LEN;
            m_fc  = sat(m_fc);
         end
         m_pp = r;
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      logic [19:0] act, exp;
      act = {flap_btn, press_pulse, busy, pending, flap_count, drop_count};
      exp = {(m_rem > 0), m_pp, (m_rem > 0), (m_pend != 0), CW'(m_fc), CW'(m_dc)};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL model_cycle: got %05h expected %05h (t=%0t)", act, exp, $time);
      end
   endtask

   task automatic tick(input logic rstn, input logic raw);
      reset_n = rstn;
      btn_raw = raw;
      @(posedge clk);
      model_step(rstn, raw);
      #1;
      check_cycle();
      if (flap_btn === 1'b1) hi_cycles++;
      if (flap_btn === 1'b1 && prev_fb !== 1'b1) hi_runs++;
      if (pending === 1'b1) pend_seen = 1'b1;
      prev_fb = flap_btn;
   endtask

   task automatic ticks(input logic rstn, input logic raw, input int n);
      for (int i = 0; i < n; i++) tick(rstn, raw);
   endtask

   task automatic clear_mon();
      hi_cycles = 0;
      hi_runs   = 0;
      pend_seen = 1'b0;
   endtask

   task automatic do_reset();
      ticks(1'b0, 1'b0, 2);
      clear_mon();
   endtask

   task automatic pulses(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         ticks(1'b1, 1'b1, hi);
         ticks(1'b1, 1'b0, lo);
      end
   endtask

   typedef struct {
      logic rstn;
      logic raw;
      int   cycles;
      int   fb;
      int   pp;
      int   pend;
      int   fc;
      int   dc;
      int   hi;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Reset with button held, then release: the press lands on the 6th edge after
      // release; held 40 edges total gives one 16-cycle window; then a 3-cycle glitch.
      tbl.push_back('{1'b0, 1'b1,  2, 0, 0, 0, 0, 0,  0});
      tbl.push_back('{1'b1, 1'b1,  5, 0, 0, 0, 0, 0,  0});
      tbl.push_back('{1'b1, 1'b1,  1, 1, 1, 0, 1, 0,  1});
      tbl.push_back('{1'b1, 1'b1, 34, 0, 0, 0, 1, 0, 16});
      tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1, 0, 16});
      tbl.push_back('{1'b1, 1'b1,  3, 0, 0, 0, 1, 0, 16});
      tbl.push_back('{1'b1, 1'b0, 12, 0, 0, 0, 1, 0, 16});

      clear_mon();
      foreach (tbl[i]) begin
         ticks(tbl[i].rstn, tbl[i].raw, tbl[i].cycles);
         check($sformatf("tbl%0d_flap_btn", i),    32'(flap_btn),    32'(tbl[i].fb));
         check($sformatf("tbl%0d_press_pulse", i), 32'(press_pulse), 32'(tbl[i].pp));
         check($sformatf("tbl%0d_busy", i),        32'(busy),        32'(tbl[i].fb));
         check($sformatf("tbl%0d_pending", i),     32'(pending),     32'(tbl[i].pend));
         check($sformatf("tbl%0d_flap_count", i),  32'(flap_count),  32'(tbl[i].fc));
         check($sformatf("tbl%0d_drop_count", i),  32'(drop_count),  32'(tbl[i].dc));
         check($sformatf("tbl%0d_hi_cycles", i),   32'(hi_cycles),   32'(tbl[i].hi));
      end

      // Queued press: second rise with hold_cnt = 8 sets pending on edge 15.
      do_reset();
      ticks(1'b1, 1'b1, 4);
      ticks(1'b1, 1'b0, 5);
      ticks(1'b1, 1'b1, 5);
      check("queued_pending_before", 32'(pending), 32'd0);
      tick(1'b1, 1'b1);
      check("queued_pending_set", 32'(pending), 32'd1);
      ticks(1'b1, 1'b1, 24);
      ticks(1'b1, 1'b0, 40);
      check("queued_hi_cycles", 32'(hi_cycles), 32'd32);
      check("queued_hi_runs",   32'(hi_runs),   32'd1);
      check("queued_flap_count", 32'(flap_count), 32'd2);
      check("queued_drop_count", 32'(drop_count), 32'd0);

      // Rise exactly on the window-end cycle with nothing queued: seamless restart.
      do_reset();
      ticks(1'b1, 1'b1, 4);
      ticks(1'b1, 1'b0, 12);
      ticks(1'b1, 1'b1, 4);
      ticks(1'b1, 1'b0, 40);
      check("restart_hi_cycles", 32'(hi_cycles), 32'd32);
      check("restart_hi_runs",   32'(hi_runs),   32'd1);
      check("restart_pend_seen", 32'(pend_seen), 32'd0);
      check("restart_flap_count", 32'(flap_count), 32'd2);
      check("restart_drop_count", 32'(drop_count), 32'd0);

      // Overflow: rises can be no closer than 2*DB edges, so four rises every 8 edges
      // give start, queue, end-with-rise (requeue) and a drop in the second window.
      do_reset();
      pulses(4, 4, 4);
      ticks(1'b1, 1'b0, 50);
      check("overflow_hi_cycles", 32'(hi_cycles), 32'd48);
      check("overflow_hi_runs",   32'(hi_runs),   32'd1);
      check("overflow_flap_count", 32'(flap_count), 32'd3);
      check("overflow_drop_count", 32'(drop_count), 32'd1);

      // Reset while hold_cnt = 5, then a fresh press gets a full window.
      do_reset();
      ticks(1'b1, 1'b1, 4);
      ticks(1'b1, 1'b0, 7);
      check("midhold_busy_before", 32'(busy), 32'd1);
      tick(1'b0, 1'b0);
      check("midhold_flap_btn", 32'(flap_btn), 32'd0);
      check("midhold_busy",     32'(busy),     32'd0);
      check("midhold_pending",  32'(pending),  32'd0);
      clear_mon();
      ticks(1'b1, 1'b1, 4);
      ticks(1'b1, 1'b0, 30);
      check("midhold_next_hi_cycles", 32'(hi_cycles), 32'd16);
      check("midhold_next_flap_count", 32'(flap_count), 32'd1);

      // Saturation: a continuous 4/4 square wave yields one accept and one drop per
      // window, well past 255 of each.
      do_reset();
      pulses(4, 4, 560);
      check("sat_flap_count", 32'(flap_count), 32'(CNT_MAX));
      check("sat_drop_count", 32'(drop_count), 32'(CNT_MAX));
      check("sat_hi_runs",    32'(hi_runs),    32'd1);
      ticks(1'b1, 1'b0, 40);
      check("sat_flap_count_hold", 32'(flap_count), 32'(CNT_MAX));

      // Random button activity with occasional resets, checked every cycle.
      do_reset();
      for (int j = 0; j < 400; j++) begin
         logic rl, rr;
         rl = 1'($urandom_range(0, 1));
         rr = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         ticks(rr, rl, $urandom_range(1, 12));
      end
      ticks(1'b1, 1'b0, 40);
      check("random_end_flap_count", 32'(flap_count), 32'(m_fc));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
